// File: rtl/msu_pkg.sv
// Shared definitions for the MSU-1 data-port prefetcher.
//   MSU_DATA_DEPTH : default ring buffer size in bytes
//   MSU_DATA_BURST : default bytes per HPS burst request
//   msu_state_e    : burst controller states
package msu_pkg;

  localparam int MSU_DATA_DEPTH = 16;
  localparam int MSU_DATA_BURST = 8;

  // DREQ / DFILL mirror REQ / FILL for a burst made stale by a seek: the
  // HPS still answers it, so its bytes are counted off and thrown away.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DREQ  = 3'd3,
    ST_DFILL = 3'd4
  } msu_state_e;

endpackage

// File: rtl/msu_byte_fifo.sv
// Byte ring buffer with head/tail pointers and an explicit fill level.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : empty the buffer (dominates write and read)
//   wr_en     : push wr_data at the tail; dropped when full
//   rd_en     : advance the head; ignored when empty
//   dout      : head byte, 0 when empty
//   level     : bytes currently held (0..DEPTH)
module msu_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_wr   = wr_en && (level_q != LW'(DEPTH));
    do_rd   = rd_en && (level_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (do_wr) tail_d = tail_q + 1'b1;
      if (do_rd) head_d = head_q + 1'b1;
      // Simultaneous push and pop leave the level unchanged.
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; the level gates what is visible.
  always_ff @(posedge clk) begin
    if (!flush && do_wr) mem_q[tail_q] <= wr_data;
  end

  assign dout  = (level_q == '0) ? 8'h00 : mem_q[head_q];
  assign level = level_q;

endmodule

// File: rtl/msu_data_prefetch.sv
// MSU-1 data port ($2001) prefetcher: keeps a byte ring buffer topped up
// from the HPS in fixed-size bursts and serves the head byte.
//   CLK, RESET         : clock, synchronous active-high reset
//   SEEK, SEEK_ADDR    : restart the stream at a byte address
//   RD_ADV             : consume the head byte
//   DOUT, LEVEL        : head byte (0 when empty), bytes buffered
//   DATA_BUSY          : status bit 7, set by seek until a burst is buffered
//   UNDERRUN           : pulse when RD_ADV finds the buffer empty
//   HPS_REQ/ADDR/ACK   : burst request channel
//   HPS_WE/DIN         : byte delivery channel
//   DBG_STATE          : controller state for observation
//
// Request handshake: HPS_REQ rises with HPS_ADDR stable and stays high,
// never withdrawn, until the HPS returns a one-cycle HPS_ACK; REQ drops
// the following cycle. After the ack exactly BURST bytes arrive, each
// marked by a one-cycle HPS_WE. Only one burst is outstanding at a time.
module msu_data_prefetch
  import msu_pkg::*;
#(
  parameter int DEPTH = MSU_DATA_DEPTH,
  parameter int BURST = MSU_DATA_BURST
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SEEK,
  input  logic [31:0]              SEEK_ADDR,
  input  logic                     RD_ADV,
  output logic [7:0]               DOUT,
  output logic                     DATA_BUSY,
  output logic                     UNDERRUN,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     HPS_REQ,
  output logic [31:0]              HPS_ADDR,
  input  logic                     HPS_ACK,
  input  logic                     HPS_WE,
  input  logic [7:0]               HPS_DIN,
  output msu_state_e               DBG_STATE
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BURST) + 1;

  msu_state_e    state_q, state_d;
  logic          fetch_en_q, fetch_en_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   hps_addr_q, hps_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          underrun_q, underrun_d;

  logic [LW-1:0] level;
  logic          fifo_wr, fifo_rd;
  logic          in_fill, in_req, last_byte, room;

  assign in_req    = (state_q == ST_REQ)  || (state_q == ST_DREQ);
  assign in_fill   = (state_q == ST_FILL) || (state_q == ST_DFILL);
  assign last_byte = HPS_WE && (cnt_q == CW'(1));
  assign room      = level <= LW'(DEPTH - BURST);
  // A seek flushes the buffer, so a byte or read in the same cycle is void.
  assign fifo_wr   = (state_q == ST_FILL) && HPS_WE && !SEEK;
  assign fifo_rd   = RD_ADV && !SEEK;

  msu_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .flush   (SEEK),
    .wr_en   (fifo_wr),
    .wr_data (HPS_DIN),
    .rd_en   (fifo_rd),
    .dout    (DOUT),
    .level   (level)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      fetch_en_q   <= 1'b0;
      fetch_addr_q <= '0;
      hps_addr_q   <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_en_q   <= fetch_en_d;
      fetch_addr_q <= fetch_addr_d;
      hps_addr_q   <= hps_addr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // The seek cycle itself never launches a request: the flush has not
      // landed yet and the fetch address is being replaced.
      ST_IDLE:  if (fetch_en_q && room && !SEEK) state_d = ST_REQ;
      ST_REQ: begin
        if (HPS_ACK)   state_d = SEEK ? ST_DFILL : ST_FILL;
        else if (SEEK) state_d = ST_DREQ;
      end
      ST_FILL: begin
        if (last_byte) state_d = ST_IDLE;
        else if (SEEK) state_d = ST_DFILL;
      end
      ST_DREQ:  if (HPS_ACK)   state_d = ST_DFILL;
      ST_DFILL: if (last_byte) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_en_d   = fetch_en_q | SEEK;
    fetch_addr_d = fetch_addr_q;
    hps_addr_d   = hps_addr_q;
    cnt_d        = cnt_q;
    if (SEEK)
      fetch_addr_d = SEEK_ADDR;
    else if ((state_q == ST_REQ) && HPS_ACK)
      fetch_addr_d = fetch_addr_q + 32'(BURST);
    // Latch the address on entry to REQ so it stays put if a seek
    // later turns the pending request stale.
    if ((state_q == ST_IDLE) && (state_d == ST_REQ))
      hps_addr_d = fetch_addr_q;
    // Every delivered byte counts down, even one dropped by a seek, so the
    // burst is tracked to its end.
    if (in_req && HPS_ACK)
      cnt_d = CW'(BURST);
    else if (in_fill && HPS_WE && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
    busy_d     = SEEK ? 1'b1 : ((level >= LW'(BURST)) ? 1'b0 : busy_q);
    underrun_d = RD_ADV && !SEEK && (level == '0);
  end

  // Busy is masked combinationally so it falls in the same cycle LEVEL
  // first shows a full burst.
  always_comb begin
    HPS_REQ   = in_req;
    HPS_ADDR  = hps_addr_q;
    DATA_BUSY = busy_q && (level < LW'(BURST));
    UNDERRUN  = underrun_q;
    LEVEL     = level;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_msu_data_prefetch.sv
module tb_msu_data_prefetch;
  import msu_pkg::*;

  localparam int DEPTH = 16;
  localparam int BURST = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, seek, rd_adv, hps_ack, hps_we;
  logic [31:0] seek_addr;
  logic [7:0]  hps_din;
  logic [7:0]  dout;
  logic        data_busy, underrun, hps_req;
  logic [4:0]  level;
  logic [31:0] hps_addr;
  msu_state_e  dbg_state;

  always #5 clk = ~clk;

  msu_data_prefetch #(.DEPTH(DEPTH), .BURST(BURST)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .SEEK      (seek),
    .SEEK_ADDR (seek_addr),
    .RD_ADV    (rd_adv),
    .DOUT      (dout),
    .DATA_BUSY (data_busy),
    .UNDERRUN  (underrun),
    .LEVEL     (level),
    .HPS_REQ   (hps_req),
    .HPS_ADDR  (hps_addr),
    .HPS_ACK   (hps_ack),
    .HPS_WE    (hps_we),
    .HPS_DIN   (hps_din),
    .DBG_STATE (dbg_state)
  );

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];      // bytes the consumer should see, in order
  bit          m_busy, m_fetch_en, m_req_out, m_stale;
  int          m_left;        // bytes still owed by the acked burst
  logic [31:0] m_fresh;       // address of the next fresh burst
  logic [31:0] m_req_addr;    // address of the request on the wire
  int          consumed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] head();
    if (exp_q.size() > 0) return exp_q[0];
    return 8'h00;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_fetch_en = 0; m_req_out = 0; m_stale = 0;
    m_left = 0; m_fresh = '0; m_req_addr = '0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit sk, input logic [31:0] sa, input bit rd,
                      input bit ack, input bit we, input logic [7:0] din);
    bit un_exp;
    chk("dout_pre", 32'(dout), 32'(head()));
    seek = sk; seek_addr = sa; rd_adv = rd; hps_ack = ack; hps_we = we; hps_din = din;
    @(posedge clk); #1;
    seek = 0; seek_addr = '0; rd_adv = 0; hps_ack = 0; hps_we = 0; hps_din = '0;

    un_exp = rd && !sk && (exp_q.size() == 0);
    if (rd && !sk && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      consumed++;
    end
    if (we && m_left > 0) begin
      m_left--;
      if (!sk && !m_stale && exp_q.size() < DEPTH) exp_q.push_back(din);
    end
    if (ack && m_req_out) begin
      m_req_out = 0;
      m_left = BURST;
      if (!m_stale) m_fresh = m_fresh + BURST;
    end
    if (sk) begin
      exp_q.delete();
      m_busy = 1; m_fetch_en = 1; m_fresh = sa;
      if (m_req_out || m_left > 0) m_stale = 1;
    end else if (exp_q.size() >= BURST) begin
      m_busy = 0;
    end
    if (!m_req_out && m_left == 0) m_stale = 0;

    chk("level", 32'(level), 32'(exp_q.size()));
    chk("dout", 32'(dout), 32'(head()));
    chk("data_busy", 32'(data_busy), 32'(m_busy));
    chk("underrun", 32'(underrun), 32'(un_exp));
    if (m_req_out) begin
      chk("hps_req_held", 32'(hps_req), 32'd1);
      chk("hps_addr_held", hps_addr, m_req_addr);
    end else if (hps_req) begin
      chk("req_allowed", 32'(m_fetch_en && m_left == 0), 32'd1);
      chk("req_room", 32'(exp_q.size() <= DEPTH - BURST), 32'd1);
      chk("req_addr", hps_addr, m_fresh);
      m_req_out = 1;
      m_req_addr = m_fresh;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, '0);
  endtask

  task automatic wait_req(input int budget, input bit drain);
    for (int i = 0; i < budget && !m_req_out; i++)
      step(0, '0, drain && (exp_q.size() > 0), 0, 0, '0);
    chk("req_timeout", 32'(m_req_out), 32'd1);
  endtask

  task automatic do_ack();
    step(0, '0, 0, 1, 0, '0);
  endtask

  // rd_mode: 0 = no reads, 1 = random reads, 2 = read with every byte
  task automatic burst(input int n, input logic [7:0] base, input bit rnd, input int rd_mode);
    bit rd;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      rd = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(0, '0, rd, 0, 1, rnd ? 8'($urandom) : 8'(base + 8'(i)));
    end
  endtask

  // Retire whatever burst is outstanding (normally a stale one).
  task automatic settle();
    if (m_req_out) do_ack();
    if (m_left > 0) burst(m_left, 8'h00, 1, 0);
  endtask

  task automatic apply_reset();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(data_busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_hps_req", 32'(hps_req), 32'd0);
    chk("rst_hps_addr", hps_addr, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; seek = 0; seek_addr = '0; rd_adv = 0; hps_ack = 0; hps_we = 0; hps_din = '0;
    consumed = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // No requests before the first seek.
    idle(5);
    chk("no_req_before_seek", 32'(hps_req), 32'd0);

    // Basic fill.
    step(1, 32'h0000_1000, 0, 0, 0, '0);
    wait_req(10, 0);
    chk("first_req_addr", hps_addr, 32'h0000_1000);
    do_ack();
    burst(8, 8'hA0, 0, 0);
    chk("busy_after_fill", 32'(data_busy), 32'd0);
    chk("level_after_fill", 32'(level), 32'd8);
    wait_req(10, 0);
    chk("second_req_addr", hps_addr, 32'h0000_1008);

    // Drain, then underrun.
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(dout), 32'(8'hA0 + 8'(i)));
      step(0, '0, 1, 0, 0, '0);
    end
    step(0, '0, 1, 0, 0, '0);
    chk("underrun_pulse", 32'(underrun), 32'd1);
    chk("underrun_dout", 32'(dout), 32'd0);
    idle(1);
    chk("underrun_one_cycle", 32'(underrun), 32'd0);
    step(0, '0, 0, 0, 1, 8'h55);   // stray byte while only requesting
    chk("we_in_req_ignored", 32'(level), 32'd0);

    // Seek while the request waits for its ack.
    step(1, 32'h0000_2000, 0, 0, 0, '0);
    chk("dreq_req_held", 32'(hps_req), 32'd1);
    chk("dreq_old_addr", hps_addr, 32'h0000_1008);
    do_ack();
    burst(8, 8'h10, 1, 0);
    chk("stale_burst_dropped", 32'(level), 32'd0);
    wait_req(10, 0);
    chk("after_dreq_addr", hps_addr, 32'h0000_2000);

    // Seek in the middle of a fill.
    do_ack();
    burst(3, 8'hB0, 0, 0);
    chk("partial_level", 32'(level), 32'd3);
    step(1, 32'h0000_3000, 0, 0, 0, '0);
    burst(5, 8'hB3, 0, 0);
    chk("dfill_level", 32'(level), 32'd0);
    chk("dfill_busy", 32'(data_busy), 32'd1);
    wait_req(10, 0);
    chk("after_dfill_addr", hps_addr, 32'h0000_3000);
    do_ack();
    burst(7, 8'hC0, 0, 0);
    chk("busy_before_full", 32'(data_busy), 32'd1);
    burst(1, 8'hC7, 0, 0);
    chk("busy_at_burst", 32'(data_busy), 32'd0);

    // Read and write in the same cycle; then seek with a read.
    wait_req(10, 0);
    do_ack();
    step(0, '0, 1, 0, 1, 8'h77);
    chk("rd_we_level", 32'(level), 32'd8);
    burst(7, 8'h00, 1, 1);
    step(1, 32'h0000_4000, 1, 0, 0, '0);
    chk("seek_rd_underrun", 32'(underrun), 32'd0);
    chk("seek_rd_level", 32'(level), 32'd0);
    settle();

    // Seek coinciding with the ack.
    wait_req(20, 0);
    chk("seek_ack_pre_addr", hps_addr, 32'h0000_4000);
    step(1, 32'h0000_5000, 0, 1, 0, '0);
    chk("seek_ack_req_drop", 32'(hps_req), 32'd0);
    burst(8, 8'h00, 1, 0);
    chk("seek_ack_dropped", 32'(level), 32'd0);
    wait_req(10, 0);
    chk("seek_ack_new_addr", hps_addr, 32'h0000_5000);

    // Address wrap and sustained streaming across pointer wrap.
    step(1, 32'hFFFF_FFF8, 0, 0, 0, '0);
    settle();
    consumed = 0;
    for (int b = 0; b < 12 && consumed < 40; b++) begin
      wait_req(40, 1);
      if (b == 0) chk("wrap_addr0", hps_addr, 32'hFFFF_FFF8);
      if (b == 1) chk("wrap_addr1", hps_addr, 32'h0000_0000);
      if (m_req_out) begin
        do_ack();
        burst(8, 8'h00, 1, 1);
      end
    end
    chk("wrap_consumed", 32'(consumed >= 40), 32'd1);

    // Reset in the middle of a burst.
    wait_req(40, 1);
    do_ack();
    burst(3, 8'hE0, 0, 0);
    apply_reset();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msu_data_prefetch.md
# msu_data_prefetch

Sequencer for the MSU-1 data port (`$2001`) byte stream. It owns a small ring buffer between the HPS file interface and the MSU register block, and issues fixed-length burst requests to the HPS at a fetch address. It presents the head byte to the register block and drives the `msu_status_data_busy` bit. It sits between the MSU register block (which supplies seek and read-advance pulses) and the HPS data channel.

## Interface
- `DEPTH`, 16, ring buffer size in bytes; power of two, ≥ 4.
- `BURST`, 8, bytes per HPS request; power of two, ≤ DEPTH/2.

- `CLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high reset.
- `SEEK`  in  1  one-cycle pulse: restart the stream at `SEEK_ADDR`.
- `SEEK_ADDR`  in  32  byte address sampled when `SEEK`=1.
- `RD_ADV`  in  1  one-cycle pulse: consume the head byte.
- `DOUT`  out  8  head byte; 0 when the buffer is empty.
- `DATA_BUSY`  out  1  MSU status bit 7.
- `UNDERRUN`  out  1  one-cycle pulse when `RD_ADV` arrives with the buffer empty.
- `LEVEL`  out  $clog2(DEPTH)+1  bytes currently buffered.
- `HPS_REQ`  out  1  burst request, held high until acknowledged.
- `HPS_ADDR`  out  32  burst start address, stable while `HPS_REQ`=1.
- `HPS_ACK`  in  1  one-cycle acceptance of the request.
- `HPS_WE`  in  1  byte strobe from the HPS.
- `HPS_DIN`  in  8  byte delivered with `HPS_WE`.

## Operation
- **Reset values:** `DOUT`=0, `DATA_BUSY`=0, `UNDERRUN`=0, `LEVEL`=0, `HPS_REQ`=0, `HPS_ADDR`=0. State is IDLE, the fetch enable is cleared, and head/tail pointers are 0.
- **Fetch enable:** fetching is disabled until the first `SEEK` after reset. Before that, no requests are issued.
- **Seek:**
  - Flush the buffer (`LEVEL`→0).
  - Set the fetch address to `SEEK_ADDR`, set `DATA_BUSY`=1, and set the fetch enable.
  - If a burst is pending or in flight, it becomes stale (see DREQ/DFILL).
- **States:**
  - IDLE → REQ when fetch is enabled and free space (DEPTH−LEVEL) ≥ BURST.
  - REQ: `HPS_REQ`=1 and `HPS_ADDR`=fetch address. On `HPS_ACK`: advance the fetch address by BURST (mod 2^32), load the remaining-byte counter with BURST, go to FILL.
  - FILL: each `HPS_WE` writes `HPS_DIN` at the tail and decrements the counter. When the counter reaches 0, go to IDLE.
  - A `SEEK` in REQ goes to DREQ. The request stays asserted; it is never withdrawn.
  - DREQ: on `HPS_ACK`, load the counter with BURST and go to DFILL. `HPS_ADDR` keeps the stale address.
  - A `SEEK` in FILL goes to DFILL and keeps the current counter.
  - DFILL: `HPS_WE` bytes are discarded and decrement the counter. When the counter reaches 0, go to IDLE.
  - A `SEEK` in DREQ or DFILL only reloads the fetch address; the state is unchanged.
- **Busy:** `DATA_BUSY` clears on the cycle `LEVEL` first reaches BURST after a seek. It is not re-asserted by later underruns.
- **Consume:** `RD_ADV` with `LEVEL`>0 advances the head and decrements `LEVEL`. With `LEVEL`=0 it is ignored and pulses `UNDERRUN`.
- **Simultaneous events:**
  - `RD_ADV`+`HPS_WE` in FILL: both take effect and `LEVEL` is unchanged.
  - `SEEK`+`RD_ADV`: the seek wins and `RD_ADV` is ignored (no `UNDERRUN`).
  - `SEEK`+`HPS_WE`: the byte is stale and is dropped.
  - `SEEK`+`HPS_ACK` in REQ: the ack is honoured, the fetch address is replaced by `SEEK_ADDR`, and the state goes to DFILL with counter=BURST.
- **Ignored / defensive cases:**
  - `HPS_WE` in IDLE or REQ is ignored.
  - `HPS_WE` with `LEVEL`=DEPTH cannot occur under the request rule. If it does occur, the byte is dropped and the pointers are unchanged.
- **Wrap-around:** pointers are $clog2(DEPTH) bits and wrap naturally. The fetch address wraps mod 2^32.

## Timing
- `RD_ADV` at cycle n: `DOUT` shows the next byte at n+1. If the buffer becomes empty, `DOUT` is 0 at n+1.
- `HPS_WE` into an empty buffer at cycle n: `DOUT` and `LEVEL` update at n+1.
- `SEEK` at cycle n: `LEVEL`=0 and `DATA_BUSY`=1 at n+1. The earliest fresh `HPS_REQ` is at n+2, or after a stale burst drains.
- `HPS_REQ` rises no earlier than the cycle after entering REQ and drops the cycle after `HPS_ACK`.
- Only one burst is outstanding at any time.
- `RESET` mid-burst: the block returns to reset values next cycle. The HPS side is also reset by the same `RESET`, so no stale-byte tracking is needed across reset.

## Structure
- Package `msu_pkg`: state enum (IDLE, REQ, FILL, DREQ, DFILL) and the default `MSU_DATA_DEPTH`/`MSU_DATA_BURST` constants.
- Sub-module `msu_byte_fifo`: dual-pointer ring buffer with synchronous flush, write, read-advance and level output.
- The controller FSM, fetch address and burst counter live in `msu_data_prefetch`.

## Test plan
- **Basic fill:** `SEEK` addr 0x00001000 → one request `HPS_ADDR`=0x1000. Deliver 8 bytes 0xA0..0xA7 → `DATA_BUSY` falls on the 8th byte, `LEVEL`=8. Next request `HPS_ADDR`=0x1008.
- **Drain:** 8 `RD_ADV` pulses → `DOUT` 0xA0..0xA7 in order. A 9th pulse on an empty buffer → `UNDERRUN` pulse, `DOUT`=0.
- **Seek mid-FILL:** `SEEK` 0x2000 after 3 of 8 bytes → 5 further bytes dropped, `LEVEL` stays 0. Next request is 0x2000 and `DATA_BUSY` stays 1 until that burst completes.
- **Seek in REQ:** `SEEK` while waiting for ack → `HPS_REQ` stays up with the old address. After ack, 8 bytes are discarded, then a request for the new address follows.
- **Wrap:** `SEEK` 0xFFFFFFF8 → requests at 0xFFFFFFF8 then 0x00000000. Sustained consume over 40 bytes → correct order across pointer wrap, `LEVEL` never exceeds 16.
- **Simultaneous:** `RD_ADV`+`HPS_WE` same cycle → `LEVEL` unchanged. `SEEK`+`RD_ADV` → no `UNDERRUN`, `LEVEL`=0.
